// File: rtl/mult_hi_lo_unit.sv
// Iterative radix-2 shift-add multiplier owning the HI/LO registers.
// Operands are converted to magnitudes on issue, multiplied unsigned over
// WIDTH iterations, and the sign is applied once in FINISH.
module mult_hi_lo_unit #(
  parameter int WIDTH       = 32,
  parameter int SIGNED_MULT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] product;
  logic               neg;
  logic [CW-1:0]      counter;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_in;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] result;

  // Operand magnitudes; the most-negative value maps to itself as unsigned.
  always_comb begin
    mag_a  = src_a;
    mag_b  = src_b;
    neg_in = 1'b0;
    if (SIGNED_MULT != 0) begin
      if (src_a[WIDTH-1]) mag_a = ~src_a + 1'b1;
      if (src_b[WIDTH-1]) mag_b = ~src_b + 1'b1;
      neg_in = src_a[WIDTH-1] ^ src_b[WIDTH-1];
    end
  end

  // One shift-add step: conditional add into the upper half, carry kept.
  always_comb begin
    sum = {1'b0, product[2*WIDTH-1:WIDTH]};
    if (product[0]) sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  end

  // Final sign application as a full 2W-bit two's-complement negate.
  always_comb begin
    result = product;
    if (neg) result = ~product + {{(2*WIDTH-1){1'b0}}, 1'b1};
  end

  // Busy depends only on the state register, never on start.
  always_comb busy = (state != IDLE);

  // Control FSM with datapath registers; HI/LO change only on the FINISH edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      product <= '0;
      neg     <= 1'b0;
      counter <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand   <= mag_a;
            product <= {{WIDTH{1'b0}}, mag_b};
            neg     <= neg_in;
            counter <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          product <= {sum, product[WIDTH-1:1]};
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH-1)) state <= FINISH;
        end
        FINISH: begin
          hi    <= result[2*WIDTH-1:WIDTH];
          lo    <= result[WIDTH-1:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hi_lo_unit.sv
// Scoreboard bench for mult_hi_lo_unit: expected products are queued at issue
// and compared whenever the signed instance pulses done.
module tb_mult_hi_lo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start_u = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] hi, lo, hi_u, lo_u;
  logic        busy, done, busy_u, done_u;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mult_hi_lo_unit #(.WIDTH(32), .SIGNED_MULT(1)) dut (
    .clock(clk), .reset(rst), .start(start), .src_a(a), .src_b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done));

  mult_hi_lo_unit #(.WIDTH(32), .SIGNED_MULT(0)) dut_u (
    .clock(clk), .reset(rst), .start(start_u), .src_a(a), .src_b(b),
    .hi(hi_u), .lo(lo_u), .busy(busy_u), .done(done_u));

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input bit sgn);
    logic signed [63:0] sx, sy;
    if (sgn) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Scoreboard: every done pulse pops and compares one queued product.
  always @(negedge clk) begin
    if (done) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_done got hi=%h lo=%h", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          n_err++;
          $display("FAIL sb_product got %h_%h exp %h", hi, lo, e);
        end
      end
    end
  end

  // Issue one signed op, then count edges until done (bounded).
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, output int lat);
    a = x; b = y; start = 1'b1;
    exp_q.push_back(model(x, y, 1'b1));
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL run_op_timeout a=%h b=%h", x, y);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      n_err++;
      $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h exp 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_basic;
    int lat;
    int busy_cnt;
    a = 32'd3; b = 32'd5; start = 1'b1;
    exp_q.push_back(model(32'd3, 32'd5, 1'b1));
    @(posedge clk); #1 start = 1'b0;
    busy_cnt = 0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) busy_cnt++;
      if (done) break;
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (busy_cnt !== 33 || lat !== 33) begin
      n_err++;
      $display("FAIL basic_latency got busy_cycles=%0d done_edge=%0d exp 33/33", busy_cnt, lat);
    end
    n_vec++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'hF) begin
      n_err++;
      $display("FAIL basic_result got busy=%b hi=%h lo=%h exp 0/0/f", busy, hi, lo);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_width got done=%b exp 0", done);
    end
  endtask

  task automatic test_corners;
    int lat;
    logic [31:0] ta[4] = '{32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] tb[4] = '{32'd6,        32'h80000000, 32'hFFFFFFFF, 32'd1};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], lat);
      n_vec++;
      if (lat !== 33) begin
        n_err++;
        $display("FAIL corner_latency idx=%0d got %0d exp 33", i, lat);
      end
      @(posedge clk); #1;
    end
    // Spot check against literal products for the most-negative case.
    n_vec++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'h80000000) begin
      n_err++;
      $display("FAIL corner_minint_x1 got %h_%h exp ffffffff_80000000", hi, lo);
    end
  endtask

  task automatic test_unsigned;
    int lat;
    a = 32'hFFFFFFF9; b = 32'd6; start_u = 1'b1;
    @(posedge clk); #1 start_u = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done_u) break;
    end
    n_vec++;
    if (done_u !== 1'b1 || lat !== 33 || hi_u !== 32'h5 || lo_u !== 32'hFFFFFFD6) begin
      n_err++;
      $display("FAIL unsigned_result got done=%b lat=%0d %h_%h exp 1/33/00000005_ffffffd6",
               done_u, lat, hi_u, lo_u);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_held;
    int lat;
    a = 32'd2; b = 32'd2; start = 1'b1;
    exp_q.push_back(model(32'd2, 32'd2, 1'b1));
    @(posedge clk); #1 a = 32'd9; b = 32'd9;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    start = 1'b0;
    n_vec++;
    if (hi !== 32'h0 || lo !== 32'h4) begin
      n_err++;
      $display("FAIL held_result got %h_%h exp 0_4", hi, lo);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL held_no_requeue got busy=%b exp 0", busy);
      end
    end
    run_op(32'd9, 32'd9, lat);
    n_vec++;
    if (lo !== 32'h51 || lat !== 33) begin
      n_err++;
      $display("FAIL held_second got lo=%h lat=%0d exp 51/33", lo, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int lat;
    run_op(32'd4, 32'd4, lat);
    @(posedge clk); #1;
    a = 32'd7; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    n_vec++;
    if (busy !== 1'b1 || lo !== 32'h10) begin
      n_err++;
      $display("FAIL abort_mid_calc got busy=%b lo=%h exp 1/10", busy, lo);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_vec++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      n_err++;
      $display("FAIL abort_reset got busy=%b done=%b hi=%h lo=%h exp 0", busy, done, hi, lo);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done) begin
        n_vec++; n_err++;
        $display("FAIL abort_stray_done got done=1 exp 0");
      end
    end
    run_op(32'h12345678, 32'hFEDCBA98, lat);
    n_vec++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL abort_recover got lat=%0d exp 33", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    int gap;
    run_op(32'h0000ABCD, 32'hFFFF0001, lat);
    a = 32'h7FFFFFFF; b = 32'h7FFFFFFF; start = 1'b1;
    exp_q.push_back(model(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1));
    gap = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      gap++;
      if (done) break;
    end
    n_vec++;
    if (done !== 1'b1 || gap !== 34) begin
      n_err++;
      $display("FAIL b2b_gap got done=%b gap=%0d exp 1/34", done, gap);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_corners();
    test_unsigned();
    test_start_held();
    test_abort();
    test_back_to_back();
    repeat (2) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
